// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush sequencer for the 5-stage core (load-use, branch flush, memory wait, watchdog trap); PIPE_PERF_CNT_EN adds perf counters.
// Zero-cycle latency: controls are combinational; a memory wait freezes every stage; a hung access traps until reset.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             trap,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2
    } state_t;

    localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wcnt, wcnt_nxt;
    logic       mem_wait;
    logic       load_use;

    assign mem_wait = mem_req & ~mem_ready;

    // $0 is hard-wired zero, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            wcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        trap       = 1'b0;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    wcnt_nxt  = wcnt + 8'd1;
                    state_nxt = (wcnt == WCNT_LAST) ? TRAP : MEM_WAIT;
                end else begin
                    state_nxt = RUN;
                    wcnt_nxt  = 8'd0;
                    if (ex_branch_taken) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                wcnt_nxt  = 8'd0;
            end
        endcase
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            trap       = 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (state != TRAP) && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            // ifid_flush is only raised by a taken-branch flush
            if (ifid_flush && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after it.
module tb_pipe_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, trap;
    logic [CW-1:0] stall_cycles, flush_events;
    logic [6:0]    ctl;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_waits;
    bit m_trapped;
    int m_stall, m_flush;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .trap(trap), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    function automatic logic [6:0] model_ctl();
        bit lu;
        if (rst || m_trapped) return 7'b0000000;
        if (mem_req && !mem_ready) return 7'b0000000;
        if (ex_branch_taken) return 7'b1111111;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        return lu ? 7'b0011101 : 7'b1111100;
    endfunction

    function automatic logic [CW-1:0] exp_stall();
`ifdef PIPE_PERF_CNT_EN
        return CW'(m_stall);
`else
        return '0;
`endif
    endfunction

    function automatic logic [CW-1:0] exp_flush();
`ifdef PIPE_PERF_CNT_EN
        return CW'(m_flush);
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        m_waits = 0; m_trapped = 0; m_stall = 0; m_flush = 0;
    endtask

    // advance one clock and update the model with what the controls were before the edge
    task automatic cycle();
        logic [6:0] e;
        bit         w;
        e = model_ctl();
        w = mem_req && !mem_ready;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_trapped) begin
            if (!e[6] && m_stall < CMAX) m_stall++;
            if (e == 7'b1111111 && m_flush < CMAX) m_flush++;
            if (w) begin
                m_waits++;
                if (m_waits >= TO) m_trapped = 1;
            end else begin
                m_waits = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_rt = 5'd3; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b0 || trap !== 1'b0) begin
            errors++; $display("FAIL reset_outputs ctl=%b trap=%b expected 0000000/0", ctl, trap);
        end
        @(posedge clk); #1;
        model_reset();
        checks++;
        if (stall_cycles !== '0 || flush_events !== '0) begin
            errors++; $display("FAIL reset_counters stall=%0d flush=%0d expected 0/0", stall_cycles, flush_events);
        end
        rst = 1'b0;
        #3;
        checks++;
        if (ctl !== 7'b1111100) begin
            errors++; $display("FAIL reset_release ctl=%b expected 1111100", ctl);
        end
        cycle();
    endtask

    task automatic test_load_use();
        idle();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #3;
        checks++;
        if (ctl !== model_ctl()) begin
            errors++; $display("FAIL load_use_stall ctl=%b expected %b", ctl, model_ctl());
        end
        cycle();
        ex_mem_read = 1'b0;
        #3;
        checks++;
        if (ctl !== model_ctl()) begin
            errors++; $display("FAIL load_use_release ctl=%b expected %b", ctl, model_ctl());
        end
        cycle();
    endtask

    task automatic test_zero_and_rt();
        idle();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #3;
        checks++;
        if (ctl !== model_ctl()) begin
            errors++; $display("FAIL reg_zero ctl=%b expected %b", ctl, model_ctl());
        end
        cycle();
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd1; id_uses_rt = 1'b0;
        #3;
        checks++;
        if (ctl !== model_ctl()) begin
            errors++; $display("FAIL rt_unused ctl=%b expected %b", ctl, model_ctl());
        end
        cycle();
        id_uses_rt = 1'b1;
        #3;
        checks++;
        if (ctl !== model_ctl()) begin
            errors++; $display("FAIL rt_used ctl=%b expected %b", ctl, model_ctl());
        end
        cycle();
        idle();
        cycle();
    endtask

    task automatic test_branch();
        idle();
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        #3;
        checks++;
        if (ctl !== model_ctl()) begin
            errors++; $display("FAIL branch_flush ctl=%b expected %b", ctl, model_ctl());
        end
        cycle();
        idle();
        #3;
        checks++;
        if (flush_events !== exp_flush()) begin
            errors++; $display("FAIL branch_count flush=%0d expected %0d", flush_events, exp_flush());
        end
        cycle();
    endtask

    task automatic test_mem_wait();
        idle();
        mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if (ctl !== model_ctl()) begin
                errors++; $display("FAIL wait_freeze%0d ctl=%b expected %b", i, ctl, model_ctl());
            end
            cycle();
        end
        mem_ready = 1'b1;
        #3;
        checks++;
        if (ctl !== model_ctl() || trap !== 1'b0) begin
            errors++; $display("FAIL wait_exit_branch ctl=%b trap=%b expected %b/0", ctl, trap, model_ctl());
        end
        checks++;
        if (stall_cycles !== exp_stall()) begin
            errors++; $display("FAIL wait_stall_count stall=%0d expected %0d", stall_cycles, exp_stall());
        end
        cycle();
        idle();
        cycle();
    endtask

    task automatic test_timeout();
        idle();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < TO + 1; i++) begin
            #3;
            checks++;
            if (trap !== m_trapped || ctl !== model_ctl()) begin
                errors++; $display("FAIL timeout_wait%0d trap=%b ctl=%b expected %b/%b", i, trap, ctl, m_trapped, model_ctl());
            end
            cycle();
        end
        mem_ready = 1'b1;
        cycle();
        #3;
        checks++;
        if (trap !== 1'b1 || ctl !== 7'b0) begin
            errors++; $display("FAIL trap_sticky trap=%b ctl=%b expected 1/0000000", trap, ctl);
        end
        checks++;
        if (stall_cycles !== exp_stall()) begin
            errors++; $display("FAIL trap_stall_count stall=%0d expected %0d", stall_cycles, exp_stall());
        end
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (trap !== 1'b0) begin
            errors++; $display("FAIL trap_async_clear trap=%b expected 0", trap);
        end
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (ctl !== 7'b1111100) begin
            errors++; $display("FAIL trap_recover ctl=%b expected 1111100", ctl);
        end
        cycle();
    endtask

    task automatic test_async_reset();
        idle();
        mem_req = 1'b1; mem_ready = 1'b0;
        cycle();
        cycle();
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (ctl !== 7'b0 || trap !== 1'b0 || stall_cycles !== '0 || flush_events !== '0) begin
            errors++; $display("FAIL async_reset ctl=%b trap=%b stall=%0d flush=%0d expected all 0", ctl, trap, stall_cycles, flush_events);
        end
        #1;
        rst = 1'b0;
        // the wait counter must have restarted, so TO-1 further waits cannot trap
        for (int i = 0; i < TO - 1; i++) begin
            cycle();
            #3;
            checks++;
            if (trap !== m_trapped) begin
                errors++; $display("FAIL async_wcnt_clear%0d trap=%b expected %b", i, trap, m_trapped);
            end
        end
        idle();
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if (m_trapped && ($urandom_range(0, 3) == 0)) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 1) == 0);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req         = ($urandom_range(0, 9) < 3);
            mem_ready       = ($urandom_range(0, 9) < 6);
            #3;
            checks++;
            if (ctl !== model_ctl() || trap !== m_trapped) begin
                errors++; $display("FAIL random%0d ctl=%b trap=%b expected %b/%b", n, ctl, trap, model_ctl(), m_trapped);
            end
            checks++;
            if (stall_cycles !== exp_stall() || flush_events !== exp_flush()) begin
                errors++; $display("FAIL random_cnt%0d stall=%0d flush=%0d expected %0d/%0d", n, stall_cycles, flush_events, exp_stall(), exp_flush());
            end
            cycle();
        end
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_zero_and_rt();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
